gf180mcu_osu_sc_gp9t3v3__lshifdown_sync_bank: RTL and testbench

//   Multi-channel down-shift receiver for signals leaving the high-voltage domain.

---
 rtl/gf180mcu_osu_sc_lshif_pkg.sv | 14 +
 rtl/gf180mcu_osu_sc_gp9t3v3__lshif_filt_ch.sv | 56 +++++
 rtl/gf180mcu_osu_sc_gp9t3v3__lshifdown_sync_bank.sv | 78 +++++++
 tb/tb_gf180mcu_osu_sc_gp9t3v3__lshifdown_sync_bank.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_osu_sc_lshif_pkg.sv
// Shared definitions for the down-shift synchroniser bank.
// Holds the parameter lower bounds and the counter-width helper.
package gf180mcu_osu_sc_lshif_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MIN_FILT_CYCLES = 1;
    localparam int MIN_CHANNELS    = 1;

    // Width of a counter that must be able to hold the value n.
    function automatic int clog2_plus1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp9t3v3__lshif_filt_ch.sv
// One channel of the bank: a plain synchroniser chain feeding a glitch filter.
// Y moves only after FILT_CYCLES consecutive samples disagree with it.
module gf180mcu_osu_sc_gp9t3v3__lshif_filt_ch
    import gf180mcu_osu_sc_lshif_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic ISO,
    input  logic READY,
    input  logic CLAMP,
    input  logic A,
    output logic Y,
    output logic CHG
);

    localparam int                CNT_W   = clog2_plus1(FILT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_y;
    logic                   r_chg;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Reset and isolation both return the channel to its clamp value and drop any pending count.
    always_ff @(posedge CLK) begin
        if (RST || ISO) begin
            r_sync <= {SYNC_STAGES{CLAMP}};
            r_y    <= CLAMP;
            r_cnt  <= '0;
            r_chg  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], A};
            r_chg  <= 1'b0;
            if (w_s == r_y) begin
                r_cnt <= '0;
            end else if (r_cnt < CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_y   <= w_s;
                r_cnt <= '0;
                r_chg <= READY;
            end
        end
    end

    assign Y   = r_y;
    assign CHG = r_chg;

endmodule

// File: rtl/gf180mcu_osu_sc_gp9t3v3__lshifdown_sync_bank.sv
// Multi-channel down-shift receiver: per-bit synchroniser plus glitch filter,
// with a shared warm-up counter that raises READY once the pipeline has settled.
module gf180mcu_osu_sc_gp9t3v3__lshifdown_sync_bank
    import gf180mcu_osu_sc_lshif_pkg::*;
#(
    parameter int                  CHANNELS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  FILT_CYCLES = 3,
    parameter logic [CHANNELS-1:0] CLAMP_VAL   = '0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] A,
    input  logic                ISO,
    output logic [CHANNELS-1:0] Y,
    output logic [CHANNELS-1:0] CHG,
    output logic                READY
);

    localparam int               WARM_CYCLES = SYNC_STAGES + FILT_CYCLES;
    localparam int               WARM_W      = clog2_plus1(WARM_CYCLES);
    localparam logic [WARM_W-1:0] WARM_LAST  = WARM_W'(WARM_CYCLES - 1);
    localparam logic [WARM_W-1:0] WARM_ONE   = WARM_W'(1);

    generate
        if (CHANNELS < MIN_CHANNELS) begin : g_bad_channels
            $error("CHANNELS must be at least %0d", MIN_CHANNELS);
        end
        if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
            $error("SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
        end
        if (FILT_CYCLES < MIN_FILT_CYCLES) begin : g_bad_filt
            $error("FILT_CYCLES must be at least %0d", MIN_FILT_CYCLES);
        end
    endgenerate

    logic [WARM_W-1:0]   r_warm;
    logic                r_ready;
    logic [CHANNELS-1:0] w_y;
    logic [CHANNELS-1:0] w_chg;

    // READY rises on the edge the warm-up count completes, then holds until the next RST or ISO.
    always_ff @(posedge CLK) begin
        if (RST || ISO) begin
            r_warm  <= '0;
            r_ready <= 1'b0;
        end else if (!r_ready) begin
            if (r_warm == WARM_LAST) begin
                r_ready <= 1'b1;
            end else begin
                r_warm <= r_warm + WARM_ONE;
            end
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            gf180mcu_osu_sc_gp9t3v3__lshif_filt_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_CYCLES (FILT_CYCLES)
            ) u_ch (
                .CLK   (CLK),
                .RST   (RST),
                .ISO   (ISO),
                .READY (r_ready),
                .CLAMP (CLAMP_VAL[i]),
                .A     (A[i]),
                .Y     (w_y[i]),
                .CHG   (w_chg[i])
            );
        end
    endgenerate

    assign Y     = w_y;
    assign CHG   = w_chg;
    assign READY = r_ready;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__lshifdown_sync_bank.sv
// Directed bench for the down-shift synchroniser bank.
// A second instance with a non-zero clamp shares the inputs to exercise CLAMP_VAL.
module tb_gf180mcu_osu_sc_gp9t3v3__lshifdown_sync_bank;

    logic       CLK;
    logic       RST;
    logic       ISO;
    logic [7:0] A;
    logic [7:0] Y;
    logic [7:0] CHG;
    logic       READY;
    logic [7:0] yClamp;
    logic [7:0] chgClamp;
    logic       readyClamp;

    int nVectors;
    int nMiscompares;

    gf180mcu_osu_sc_gp9t3v3__lshifdown_sync_bank #(
        .CHANNELS    (8),
        .SYNC_STAGES (2),
        .FILT_CYCLES (3),
        .CLAMP_VAL   (8'h00)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .A     (A),
        .ISO   (ISO),
        .Y     (Y),
        .CHG   (CHG),
        .READY (READY)
    );

    gf180mcu_osu_sc_gp9t3v3__lshifdown_sync_bank #(
        .CHANNELS    (8),
        .SYNC_STAGES (2),
        .FILT_CYCLES (3),
        .CLAMP_VAL   (8'hA5)
    ) dutClamp (
        .CLK   (CLK),
        .RST   (RST),
        .A     (A),
        .ISO   (ISO),
        .Y     (yClamp),
        .CHG   (chgClamp),
        .READY (readyClamp)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic rst, input logic iso, input logic [7:0] a);
        RST = rst;
        ISO = iso;
        A   = a;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        nVectors++;
        assert (observed === expected)
        else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Release from reset/ISO with A=FF: Y and READY both move at the fifth edge, CHG stays quiet.
    task automatic warmupCheck(input string tag);
        applyStimulus(1'b0, 1'b0, 8'hFF);
        for (int e = 1; e <= 6; e++) begin
            tick();
            checkOutput({tag, "_y"},      Y,               (e >= 5) ? 8'hFF : 8'h00);
            checkOutput({tag, "_ready"},  {7'd0, READY},   (e >= 5) ? 8'h01 : 8'h00);
            checkOutput({tag, "_chg"},    CHG,             8'h00);
            checkOutput({tag, "_yclamp"}, yClamp,          (e >= 5) ? 8'hFF : 8'hA5);
            checkOutput({tag, "_chgclamp"}, chgClamp,      8'h00);
        end
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;

        // Test 1: reset with A=FF, then warm-up
        applyStimulus(1'b1, 1'b0, 8'hFF);
        for (int e = 1; e <= 2; e++) begin
            tick();
            checkOutput("t1_rst_y",      Y,             8'h00);
            checkOutput("t1_rst_chg",    CHG,           8'h00);
            checkOutput("t1_rst_ready",  {7'd0, READY}, 8'h00);
            checkOutput("t1_rst_yclamp", yClamp,        8'hA5);
        end
        warmupCheck("t1_warm");

        // Bring Y back to 00 with READY=1: all eight CHG bits pulse together
        applyStimulus(1'b0, 1'b0, 8'h00);
        for (int e = 1; e <= 6; e++) begin
            tick();
            checkOutput("t2_clr_y",   Y,   (e >= 5) ? 8'h00 : 8'hFF);
            checkOutput("t2_clr_chg", CHG, (e == 5) ? 8'hFF : 8'h00);
        end

        // Test 2: single channel rise
        applyStimulus(1'b0, 1'b0, 8'h08);
        for (int e = 1; e <= 7; e++) begin
            tick();
            checkOutput("t2_y",   Y,   (e >= 5) ? 8'h08 : 8'h00);
            checkOutput("t2_chg", CHG, (e == 5) ? 8'h08 : 8'h00);
        end

        // Test 3: two-cycle glitch on A[0] is filtered out
        applyStimulus(1'b0, 1'b0, 8'h09);
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 2) applyStimulus(1'b0, 1'b0, 8'h08);
            checkOutput("t3_y",   Y,   8'h08);
            checkOutput("t3_chg", CHG, 8'h00);
        end

        // Test 4: three-cycle pulse on A[0] passes with one CHG per edge
        applyStimulus(1'b0, 1'b0, 8'h09);
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 3) applyStimulus(1'b0, 1'b0, 8'h08);
            checkOutput("t4_y",   Y,   (e >= 5 && e < 8) ? 8'h09 : 8'h08);
            checkOutput("t4_chg", CHG, (e == 5 || e == 8) ? 8'h01 : 8'h00);
        end

        // Test 5: isolation with Y=FF
        applyStimulus(1'b0, 1'b0, 8'hFF);
        for (int e = 1; e <= 6; e++) tick();
        checkOutput("t5_pre_y",     Y,             8'hFF);
        checkOutput("t5_pre_ready", {7'd0, READY}, 8'h01);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        for (int e = 1; e <= 3; e++) begin
            tick();
            checkOutput("t5_iso_y",      Y,             8'h00);
            checkOutput("t5_iso_ready",  {7'd0, READY}, 8'h00);
            checkOutput("t5_iso_chg",    CHG,           8'h00);
            checkOutput("t5_iso_yclamp", yClamp,        8'hA5);
        end
        warmupCheck("t5_warm");

        // Test 6: reset aborts a pending count on channel 5
        applyStimulus(1'b0, 1'b0, 8'hDF);
        for (int e = 1; e <= 4; e++) begin
            tick();
            checkOutput("t6_cnt_y",   Y,   8'hFF);
            checkOutput("t6_cnt_chg", CHG, 8'h00);
        end
        applyStimulus(1'b1, 1'b0, 8'hFF);
        for (int e = 1; e <= 2; e++) begin
            tick();
            checkOutput("t6_rst_y",      Y,             8'h00);
            checkOutput("t6_rst_chg",    CHG,           8'h00);
            checkOutput("t6_rst_ready",  {7'd0, READY}, 8'h00);
            checkOutput("t6_rst_yclamp", yClamp,        8'hA5);
        end
        warmupCheck("t6_warm");

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
